// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port round-robin arbiter.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Index width for a requester vector of n entries (never narrower than 1 bit)
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any_req
);

  logic [IDX_W:0]   cand_s;
  logic [IDX_W-1:0] cand_idx_s;
  logic             found_s;

  // Scan from ptr upward; the extra bit in cand_s lets the wrap work for non-power-of-two counts
  always_comb begin
    grant      = '0;
    idx        = '0;
    found_s    = 1'b0;
    cand_s     = '0;
    cand_idx_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_s = {1'b0, ptr} + (IDX_W+1)'(i);
      if (cand_s >= (IDX_W+1)'(NUM_REQ)) begin
        cand_s = cand_s - (IDX_W+1)'(NUM_REQ);
      end else begin
        cand_s = cand_s;
      end
      cand_idx_s = cand_s[IDX_W-1:0];
      if (!found_s && req[cand_idx_s]) begin
        found_s           = 1'b1;
        idx               = cand_idx_s;
        grant[cand_idx_s] = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ valid/ready requesters.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DWIDTH    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                              clk_i,
  input  logic                              arst_i,
  input  logic [NUM_REQ-1:0][DWIDTH-1:0]    req_data_i,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  output logic [DWIDTH-1:0]                 fifo_data_o,
  output logic                              fifo_wrreq_o,
  input  logic                              fifo_full_i,
  output logic [NUM_REQ-1:0]                grant_o,
  output logic [$clog2(NUM_REQ)-1:0]        grant_id_o,
  output logic                              busy_o
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  state_t             state_r, state_nx_s;
  logic [IDX_W-1:0]   rr_ptr_r, rr_ptr_nx_s;
  logic [IDX_W-1:0]   grant_id_r, grant_id_nx_s;
  logic [CNT_W-1:0]   burst_cnt_r, burst_cnt_nx_s;
  logic [NUM_REQ-1:0] grant_r, grant_nx_s;
  logic               busy_r, busy_nx_s;

  logic [NUM_REQ-1:0] pick_grant_s;
  logic [IDX_W-1:0]   pick_idx_s;
  logic               pick_any_s;
  logic               g_valid_s;
  logic               beat_s;
  logic [IDX_W-1:0]   next_ptr_s;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req     (req_valid_i),
    .ptr     (rr_ptr_r),
    .grant   (pick_grant_s),
    .idx     (pick_idx_s),
    .any_req (pick_any_s)
  );

  assign g_valid_s = req_valid_i[grant_id_r];
  assign beat_s    = (state_r == GRANT) && g_valid_s && !fifo_full_i;

  // Handshake and write-port drive; ready follows full combinationally so a full cycle never beats
  always_comb begin
    req_ready_o  = '0;
    fifo_wrreq_o = beat_s;
    fifo_data_o  = req_data_i[grant_id_r];
    if (state_r == GRANT) begin
      req_ready_o[grant_id_r] = !fifo_full_i;
    end else begin
      req_ready_o = '0;
    end
  end

  // Pointer advances past the releasing requester with an explicit wrap
  always_comb begin
    if (grant_id_r == IDX_W'(NUM_REQ - 1)) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = grant_id_r + IDX_W'(1);
    end
  end

  // Next-state logic for the IDLE/GRANT burst FSM
  always_comb begin
    state_nx_s     = state_r;
    rr_ptr_nx_s    = rr_ptr_r;
    grant_id_nx_s  = grant_id_r;
    burst_cnt_nx_s = burst_cnt_r;
    grant_nx_s     = grant_r;
    busy_nx_s      = busy_r;
    case (state_r)
      IDLE: begin
        if (pick_any_s) begin
          state_nx_s     = GRANT;
          grant_nx_s     = pick_grant_s;
          grant_id_nx_s  = pick_idx_s;
          burst_cnt_nx_s = '0;
          busy_nx_s      = 1'b1;
        end else begin
          state_nx_s = IDLE;
        end
      end
      GRANT: begin
        if (beat_s) begin
          burst_cnt_nx_s = burst_cnt_r + CNT_W'(1);
        end else begin
          burst_cnt_nx_s = burst_cnt_r;
        end
        // A dropped valid and a final beat in the same cycle collapse into one release
        if (!g_valid_s || (beat_s && (burst_cnt_r == CNT_W'(MAX_BURST - 1)))) begin
          state_nx_s  = IDLE;
          grant_nx_s  = '0;
          busy_nx_s   = 1'b0;
          rr_ptr_nx_s = next_ptr_s;
        end else begin
          state_nx_s = GRANT;
        end
      end
      default: begin
        state_nx_s = IDLE;
        grant_nx_s = '0;
        busy_nx_s  = 1'b0;
      end
    endcase
  end

  // State and registered grant outputs
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_r     <= IDLE;
      rr_ptr_r    <= '0;
      grant_id_r  <= '0;
      burst_cnt_r <= '0;
      grant_r     <= '0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      rr_ptr_r    <= rr_ptr_nx_s;
      grant_id_r  <= grant_id_nx_s;
      burst_cnt_r <= burst_cnt_nx_s;
      grant_r     <= grant_nx_s;
      busy_r      <= busy_nx_s;
    end
  end

  assign grant_o    = grant_r;
  assign grant_id_o = grant_id_r;
  assign busy_o     = busy_r;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: per-requester word sources, expected (id,data) queue.
module tb_fifo_wr_arbiter;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] data;
  } sb_t;

  logic             clk = 1'b0;
  logic             arst;
  logic [3:0][31:0] req_data;
  logic [3:0]       req_valid;
  logic [3:0]       req_ready;
  logic [31:0]      fifo_data;
  logic             fifo_wrreq;
  logic             fifo_full;
  logic [3:0]       grant;
  logic [1:0]       grant_id;
  logic             busy;

  logic [31:0] src_idx[4];
  logic [31:0] src_len[4];
  logic [31:0] src_base[4];
  logic [31:0] src_start[4];
  logic [3:0]  en;
  logic [3:0]  pend;
  sb_t         sb_q[$];
  sb_t         exp_e;
  int          checks = 0;
  int          failures = 0;

  fifo_wr_arbiter #(.NUM_REQ(4), .DWIDTH(32), .MAX_BURST(4)) dut (
    .clk_i        (clk),
    .arst_i       (arst),
    .req_data_i   (req_data),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .fifo_data_o  (fifo_data),
    .fifo_wrreq_o (fifo_wrreq),
    .fifo_full_i  (fifo_full),
    .grant_o      (grant),
    .grant_id_o   (grant_id),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      req_valid[i] = en[i] && (src_idx[i] < src_len[i]);
      req_data[i]  = src_base[i] + (src_idx[i] - src_start[i]);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (pend[i]) src_idx[i] = src_idx[i] + 32'd1;
    pend = 4'b0000;
  endtask

  task automatic observe();
    @(negedge clk);
    if (fifo_wrreq) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_write: got id=%0d data=%h, required no write", grant_id, fifo_data);
      end else begin
        exp_e = sb_q.pop_front();
        if (grant_id !== exp_e.id || fifo_data !== exp_e.data) begin
          failures++;
          $display("FAIL sb_word: got id=%0d data=%h, required id=%0d data=%h",
                   grant_id, fifo_data, exp_e.id, exp_e.data);
        end
      end
    end
    pend = req_valid & req_ready;
  endtask

  task automatic start_src(input int id, input logic [31:0] base, input int n);
    src_base[id]  = base;
    src_start[id] = src_idx[id];
    src_len[id]   = src_idx[id] + 32'(n);
    en[id]        = 1'b1;
  endtask

  task automatic expect_words(input int id, input int first, input int n);
    for (int k = 0; k < n; k++) sb_q.push_back('{id: 2'(id), data: src_base[id] + 32'(first + k)});
  endtask

  task automatic apply_reset();
    arst = 1'b1;
    en = 4'b0000;
    fifo_full = 1'b0;
    pend = 4'b0000;
    sb_q.delete();
    next_cycle();
    next_cycle();
    arst = 1'b0;
  endtask

  task automatic test_reset();
    arst = 1'b1;
    for (int i = 0; i < 4; i++) start_src(i, 32'h900 + 32'(i * 16), 1);
    for (int i = 0; i < 4; i++) expect_words(i, 0, 1);
    observe();
    checks++;
    if (grant !== 4'b0000 || grant_id !== 2'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_regs: got grant=%b id=%0d busy=%b, required 0000/0/0", grant, grant_id, busy);
    end
    checks++;
    if (req_ready !== 4'b0000 || fifo_wrreq !== 1'b0) begin
      failures++;
      $display("FAIL reset_handshake: got ready=%b wrreq=%b, required 0000/0", req_ready, fifo_wrreq);
    end
    next_cycle();
    arst = 1'b0;
    observe();
    next_cycle();
    observe();
    checks++;
    if (grant !== 4'b0001) begin
      failures++;
      $display("FAIL reset_first_grant: got %b, required 0001", grant);
    end
    for (int c = 0; c < 14; c++) begin next_cycle(); observe(); end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL reset_drain: got %0d words left, required 0", sb_q.size());
    end
  endtask

  task automatic test_single();
    int pulses = 0;
    apply_reset();
    start_src(2, 32'h10, 8);
    expect_words(2, 0, 8);
    observe();
    for (int c = 1; c <= 14; c++) begin
      next_cycle();
      observe();
      if (fifo_wrreq) pulses++;
      if (c == 1 || c == 6) begin
        checks++;
        if (grant !== 4'b0100 || grant_id !== 2'd2) begin
          failures++;
          $display("FAIL single_grant c%0d: got %b/%0d, required 0100/2", c, grant, grant_id);
        end
      end
      if (c == 5) begin
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b0 || fifo_wrreq !== 1'b0) begin
          failures++;
          $display("FAIL single_bubble: got grant=%b busy=%b wrreq=%b, required 0000/0/0", grant, busy, fifo_wrreq);
        end
      end
    end
    checks++;
    if (pulses != 8 || sb_q.size() != 0) begin
      failures++;
      $display("FAIL single_count: got pulses=%0d left=%0d, required 8/0", pulses, sb_q.size());
    end
  endtask

  task automatic test_round_robin();
    int last_id = -1;
    int grants = 0;
    int beats_in = 0;
    logic prev_busy = 1'b0;
    apply_reset();
    for (int i = 0; i < 4; i++) start_src(i, 32'h1000 * 32'(i + 1), 8);
    for (int r = 0; r < 2; r++) for (int i = 0; i < 4; i++) expect_words(i, r * 4, 4);
    for (int c = 0; c < 50; c++) begin
      observe();
      if (busy && !prev_busy) begin
        grants++;
        beats_in = 0;
        checks++;
        if (int'(grant_id) == last_id) begin
          failures++;
          $display("FAIL rr_repeat: got id=%0d twice, required a different id", grant_id);
        end
        last_id = int'(grant_id);
      end
      if (fifo_wrreq) beats_in++;
      if (!busy && prev_busy) begin
        checks++;
        if (beats_in != 4) begin
          failures++;
          $display("FAIL rr_burst_len: got %0d beats, required 4", beats_in);
        end
      end
      prev_busy = busy;
      next_cycle();
    end
    checks++;
    if (grants != 8 || sb_q.size() != 0) begin
      failures++;
      $display("FAIL rr_totals: got grants=%0d left=%0d, required 8/0", grants, sb_q.size());
    end
  endtask

  task automatic test_full();
    apply_reset();
    start_src(0, 32'hA0, 4);
    expect_words(0, 0, 4);
    observe();
    for (int c = 1; c <= 8; c++) begin
      next_cycle();
      if (c == 3) fifo_full = 1'b1;
      if (c == 6) fifo_full = 1'b0;
      observe();
      if (c >= 3 && c <= 5) begin
        checks++;
        if (req_ready !== 4'b0000 || fifo_wrreq !== 1'b0 || grant !== 4'b0001) begin
          failures++;
          $display("FAIL full_stall c%0d: got ready=%b wrreq=%b grant=%b, required 0000/0/0001",
                   c, req_ready, fifo_wrreq, grant);
        end
      end
      if (c == 6 || c == 7) begin
        checks++;
        if (fifo_wrreq !== 1'b1 || grant !== 4'b0001) begin
          failures++;
          $display("FAIL full_resume c%0d: got wrreq=%b grant=%b, required 1/0001", c, fifo_wrreq, grant);
        end
      end
      if (c == 8) begin
        checks++;
        if (grant !== 4'b0000) begin
          failures++;
          $display("FAIL full_release: got grant=%b, required 0000", grant);
        end
      end
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL full_drain: got %0d words left, required 0", sb_q.size());
    end
  endtask

  task automatic test_early_release();
    apply_reset();
    start_src(1, 32'h110, 4);
    start_src(3, 32'h330, 4);
    expect_words(1, 0, 2);
    expect_words(3, 0, 4);
    observe();
    next_cycle();
    observe();
    checks++;
    if (grant !== 4'b0010) begin
      failures++;
      $display("FAIL early_first: got %b, required 0010", grant);
    end
    next_cycle();
    observe();
    next_cycle();
    en[1] = 1'b0;
    start_src(0, 32'h200, 4);
    expect_words(0, 0, 4);
    observe();
    checks++;
    if (fifo_wrreq !== 1'b0 || grant !== 4'b0010) begin
      failures++;
      $display("FAIL early_drop: got wrreq=%b grant=%b, required 0/0010", fifo_wrreq, grant);
    end
    next_cycle();
    observe();
    checks++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL early_idle: got grant=%b busy=%b, required 0000/0", grant, busy);
    end
    next_cycle();
    observe();
    checks++;
    if (grant !== 4'b1000 || grant_id !== 2'd3) begin
      failures++;
      $display("FAIL early_next: got %b/%0d, required 1000/3", grant, grant_id);
    end
    for (int c = 0; c < 12; c++) begin next_cycle(); observe(); end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL early_drain: got %0d words left, required 0", sb_q.size());
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    start_src(1, 32'h510, 4);
    expect_words(1, 0, 4);
    for (int c = 0; c < 5; c++) begin observe(); next_cycle(); end
    start_src(0, 32'h500, 8);
    expect_words(0, 0, 3);
    observe();
    for (int c = 0; c < 3; c++) begin next_cycle(); observe(); end
    checks++;
    if (fifo_wrreq !== 1'b1 || grant !== 4'b0001) begin
      failures++;
      $display("FAIL areset_pre: got wrreq=%b grant=%b, required 1/0001", fifo_wrreq, grant);
    end
    #2;
    arst = 1'b1;
    #1;
    checks++;
    if (grant !== 4'b0000 || req_ready !== 4'b0000 || fifo_wrreq !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL areset_immediate: got grant=%b ready=%b wrreq=%b busy=%b, required 0000/0000/0/0",
               grant, req_ready, fifo_wrreq, busy);
    end
    pend = 4'b0000;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL areset_sb: got %0d words left, required 0", sb_q.size());
    end
    next_cycle();
    observe();
    next_cycle();
    arst = 1'b0;
    start_src(2, 32'h520, 4);
    expect_words(0, 2, 4);
    expect_words(2, 0, 4);
    expect_words(0, 6, 2);
    observe();
    next_cycle();
    observe();
    checks++;
    if (grant !== 4'b0001 || grant_id !== 2'd0) begin
      failures++;
      $display("FAIL areset_regrant: got %b/%0d, required 0001/0", grant, grant_id);
    end
    for (int c = 0; c < 20; c++) begin next_cycle(); observe(); end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL areset_drain: got %0d words left, required 0", sb_q.size());
    end
  endtask

  initial begin
    arst = 1'b0;
    fifo_full = 1'b0;
    en = 4'b0000;
    pend = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      src_idx[i] = '0;
      src_len[i] = '0;
      src_base[i] = '0;
      src_start[i] = '0;
    end
    #2;
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_early_release();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
